// File: rtl/layer_scheduler_pkg.sv
// Shared model-manager definitions: layer-table field types and the scheduler's
// state encoding, kept as plain constants so legacy code can compare against them.
package layer_scheduler_pkg;

  typedef logic [3:0]  layer_opcode;
  typedef logic [15:0] mem_handle_t;

  typedef logic [2:0] sched_state_t;
  localparam sched_state_t ST_IDLE  = 3'd0;
  localparam sched_state_t ST_FETCH = 3'd1;
  localparam sched_state_t ST_ISSUE = 3'd2;
  localparam sched_state_t ST_WAIT  = 3'd3;
  localparam sched_state_t ST_DONE  = 3'd4;

  localparam logic [4:0] MAX_LAYERS = 5'd16;

  // Oversized requests clamp to the full 16-entry table.
  function automatic logic [3:0] last_index(input logic [4:0] n);
    if (n >= MAX_LAYERS) return 4'd15;
    return n[3:0] - 4'd1;
  endfunction

endpackage

// File: rtl/layer_scheduler.sv
// Layer scheduler: walks the layer table forward (then backward when training),
// issuing one compute-engine job per layer, with abort and sticky protocol errors.
module layer_scheduler
  import layer_scheduler_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         train,
  input  logic         abort,
  input  logic [4:0]   num_layers,
  output logic         lt_rd_en,
  output logic [3:0]   lt_idx,
  input  layer_opcode  lt_opcode,
  input  mem_handle_t  lt_scratch,
  input  mem_handle_t  lt_weight,
  input  mem_handle_t  lt_bias,
  output logic         job_valid,
  input  logic         job_ready,
  output logic [3:0]   job_layer,
  output logic         job_bwd,
  output layer_opcode  job_opcode,
  output mem_handle_t  job_scratch,
  output mem_handle_t  job_weight,
  output mem_handle_t  job_bias,
  input  logic         eng_done,
  output logic         busy,
  output logic         run_done,
  output logic         aborted,
  output logic         err
);

  sched_state_t state;
  logic [3:0]   idx;
  logic [3:0]   last_idx;
  logic         dir;
  logic         train_q;

  // Table data is held by the table between reads, so jobs are a direct pass-through.
  always_comb begin
    lt_rd_en    = (state == ST_FETCH);
    lt_idx      = idx;
    job_valid   = (state == ST_ISSUE);
    job_layer   = idx;
    job_bwd     = dir;
    job_opcode  = lt_opcode;
    job_scratch = lt_scratch;
    job_weight  = lt_weight;
    job_bias    = lt_bias;
    busy        = (state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= 4'd0;
      dir      <= 1'b0;
      train_q  <= 1'b0;
      last_idx <= 4'd0;
      err      <= 1'b0;
      run_done <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      run_done <= 1'b0;
      aborted  <= 1'b0;
      if ((eng_done && state != ST_WAIT) || (start && state != ST_IDLE))
        err <= 1'b1;

      // Abort outranks every other event once a run is in flight.
      if (abort && state != ST_IDLE) begin
        state   <= ST_IDLE;
        aborted <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              train_q  <= train;
              last_idx <= last_index(num_layers);
              idx      <= 4'd0;
              dir      <= 1'b0;
              if (num_layers > MAX_LAYERS) err <= 1'b1;
              state    <= (num_layers == 5'd0) ? ST_DONE : ST_FETCH;
            end
          end
          ST_FETCH: state <= ST_ISSUE;
          ST_ISSUE: if (job_ready) state <= ST_WAIT;
          ST_WAIT: begin
            // Boundary checks come before any step, so idx never wraps.
            if (eng_done) begin
              if (!dir) begin
                if (idx < last_idx) begin
                  idx   <= idx + 4'd1;
                  state <= ST_FETCH;
                end else if (train_q) begin
                  dir   <= 1'b1;
                  state <= ST_FETCH;
                end else begin
                  state <= ST_DONE;
                end
              end else if (idx > 4'd0) begin
                idx   <= idx - 4'd1;
                state <= ST_FETCH;
              end else begin
                state <= ST_DONE;
              end
            end
          end
          ST_DONE: begin
            run_done <= 1'b1;
            state    <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_layer_scheduler.sv
// Self-checking bench for layer_scheduler: randomized table contents and engine
// timing compared against an expected job list built from the layer count.
module tb_layer_scheduler;
  import layer_scheduler_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, train, abort, job_ready, eng_done;
  logic [4:0]  num_layers;
  logic        lt_rd_en;
  logic [3:0]  lt_idx;
  layer_opcode lt_opcode;
  mem_handle_t lt_scratch, lt_weight, lt_bias;
  logic        job_valid, job_bwd;
  logic [3:0]  job_layer;
  layer_opcode job_opcode;
  mem_handle_t job_scratch, job_weight, job_bias;
  logic        busy, run_done, aborted, err;

  int n_checks = 0;
  int n_fail   = 0;

  layer_opcode tbl_op[16];
  mem_handle_t tbl_scr[16], tbl_wt[16], tbl_bi[16];

  always #5 clk = ~clk;

  layer_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .train(train), .abort(abort),
    .num_layers(num_layers), .lt_rd_en(lt_rd_en), .lt_idx(lt_idx),
    .lt_opcode(lt_opcode), .lt_scratch(lt_scratch), .lt_weight(lt_weight),
    .lt_bias(lt_bias), .job_valid(job_valid), .job_ready(job_ready),
    .job_layer(job_layer), .job_bwd(job_bwd), .job_opcode(job_opcode),
    .job_scratch(job_scratch), .job_weight(job_weight), .job_bias(job_bias),
    .eng_done(eng_done), .busy(busy), .run_done(run_done), .aborted(aborted),
    .err(err)
  );

  // Layer table: one-cycle read latency, data held until the next read.
  initial begin
    lt_opcode = '0; lt_scratch = '0; lt_weight = '0; lt_bias = '0;
    forever begin
      @(posedge clk);
      if (lt_rd_en) begin
        lt_opcode  = tbl_op[lt_idx];
        lt_scratch = tbl_scr[lt_idx];
        lt_weight  = tbl_wt[lt_idx];
        lt_bias    = tbl_bi[lt_idx];
      end
    end
  end

  task automatic randomize_table();
    for (int i = 0; i < 16; i++) begin
      tbl_op[i]  = layer_opcode'($urandom_range(0, 15));
      tbl_scr[i] = mem_handle_t'($urandom);
      tbl_wt[i]  = mem_handle_t'($urandom);
      tbl_bi[i]  = mem_handle_t'($urandom);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; abort = 1'b0; eng_done = 1'b0; job_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One complete run; ready_mode 0 = tied high, 1 = random, 2 = low for 5 ISSUE cycles per job.
  task automatic run_and_check(input string name, input int n, input bit tr,
                               input int ready_mode, input bit inject_start);
    int          exp_layer[$];
    bit          exp_bwd[$];
    int          n_eff, total, job_i, cd, issue_cnt, done_cyc, cyc, delay;
    bit          hold, exp_err;
    logic [3:0]  h_layer;
    logic        h_bwd;
    layer_opcode h_op;
    mem_handle_t h_scr, h_wt, h_bi;

    n_eff = (n > 16) ? 16 : n;
    for (int i = 0; i < n_eff; i++) begin
      exp_layer.push_back(i); exp_bwd.push_back(1'b0);
    end
    if (tr)
      for (int i = n_eff - 1; i >= 0; i--) begin
        exp_layer.push_back(i); exp_bwd.push_back(1'b1);
      end
    total   = exp_layer.size();
    exp_err = (n > 16) || inject_start;
    randomize_table();

    @(negedge clk);
    start = 1'b1; train = tr; num_layers = 5'(n); eng_done = 1'b0; abort = 1'b0;
    job_ready = (ready_mode == 0);
    cyc = 0; job_i = 0; cd = -1; issue_cnt = 0; done_cyc = -1; hold = 1'b0;
    h_layer = '0; h_bwd = 1'b0; h_op = '0; h_scr = '0; h_wt = '0; h_bi = '0;

    while (done_cyc < 0 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;

      if (cyc == 1 && n_eff > 0) begin
        n_checks++;
        if ({lt_rd_en, lt_idx} !== 5'b1_0000) begin
          n_fail++;
          $display("[TB] FAIL %s first_fetch: got rd=%0b idx=%0d, want rd=1 idx=0", name, lt_rd_en, lt_idx);
        end
      end
      if (cyc == 2 && n_eff > 0) begin
        n_checks++;
        if (job_valid !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL %s first_issue: got job_valid=%0b, want 1", name, job_valid);
        end
      end
      if (eng_done && job_i < total) begin
        n_checks++;
        if (lt_rd_en !== 1'b1 || lt_idx !== 4'(exp_layer[job_i])) begin
          n_fail++;
          $display("[TB] FAIL %s next_fetch: got rd=%0b idx=%0d, want rd=1 idx=%0d",
                   name, lt_rd_en, lt_idx, exp_layer[job_i]);
        end
      end
      if (aborted) begin
        n_checks++; n_fail++;
        $display("[TB] FAIL %s stray_abort: got aborted=1, want 0", name);
      end
      if (job_valid && hold) begin
        n_checks++;
        if ({job_layer, job_bwd, job_opcode, job_scr_w(), job_weight, job_bias} !==
            {h_layer, h_bwd, h_op, h_scr, h_wt, h_bi}) begin
          n_fail++;
          $display("[TB] FAIL %s hold_stable: got L%0d op=%h scr=%h, want L%0d op=%h scr=%h",
                   name, job_layer, job_opcode, job_scratch, h_layer, h_op, h_scr);
        end
      end
      if (run_done) done_cyc = cyc;

      if (cd > 0) cd--;
      eng_done = (cd == 0);
      if (cd == 0) cd = -1;
      if (inject_start && cyc == 3) begin
        start = 1'b1; train = ~tr; num_layers = 5'd7;
      end
      case (ready_mode)
        0:       job_ready = 1'b1;
        1:       job_ready = 1'($urandom_range(0, 1));
        default: begin
          job_ready = job_valid && (issue_cnt >= 5);
          if (job_valid && issue_cnt < 5) issue_cnt++;
        end
      endcase

      if (job_valid && job_ready) begin
        n_checks++;
        if (job_i >= total) begin
          n_fail++;
          $display("[TB] FAIL %s extra_job: got L%0d bwd=%0b, want no job", name, job_layer, job_bwd);
        end else if (job_layer !== 4'(exp_layer[job_i]) || job_bwd !== exp_bwd[job_i] ||
                     job_opcode !== tbl_op[exp_layer[job_i]] || job_scratch !== tbl_scr[exp_layer[job_i]] ||
                     job_weight !== tbl_wt[exp_layer[job_i]] || job_bias !== tbl_bi[exp_layer[job_i]]) begin
          n_fail++;
          $display("[TB] FAIL %s job%0d: got L%0d bwd=%0b op=%h w=%h, want L%0d bwd=%0b op=%h w=%h",
                   name, job_i, job_layer, job_bwd, job_opcode, job_weight, exp_layer[job_i],
                   exp_bwd[job_i], tbl_op[exp_layer[job_i]], tbl_wt[exp_layer[job_i]]);
        end
        job_i++;
        delay = (ready_mode == 1) ? int'($urandom_range(1, 4)) : 2;
        cd = delay; hold = 1'b0; issue_cnt = 0;
      end else if (job_valid) begin
        hold = 1'b1;
        h_layer = job_layer; h_bwd = job_bwd; h_op = job_opcode;
        h_scr = job_scratch; h_wt = job_weight; h_bi = job_bias;
      end
    end

    eng_done = 1'b0; job_ready = 1'b0;
    n_checks++;
    if (done_cyc < 0 || job_i != total) begin
      n_fail++;
      $display("[TB] FAIL %s completion: got done_cyc=%0d jobs=%0d, want done with jobs=%0d",
               name, done_cyc, job_i, total);
    end
    if (n == 0) begin
      n_checks++;
      if (done_cyc != 2) begin
        n_fail++;
        $display("[TB] FAIL %s empty_done_latency: got %0d, want 2", name, done_cyc);
      end
    end
    n_checks++;
    if (err !== exp_err) begin
      n_fail++;
      $display("[TB] FAIL %s err: got %0b, want %0b", name, err, exp_err);
    end
    @(negedge clk);
    n_checks++;
    if ({run_done, busy} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL %s done_pulse: got run_done=%0b busy=%0b, want 0 0", name, run_done, busy);
    end
  endtask

  function automatic mem_handle_t job_scr_w();
    return job_scratch;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({job_valid, lt_rd_en, busy, run_done, aborted, err, job_bwd, lt_idx, job_layer} !== 15'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got v=%0b rd=%0b busy=%0b done=%0b ab=%0b err=%0b, want all 0",
               job_valid, lt_rd_en, busy, run_done, aborted, err);
    end
    rst = 1'b0;
  endtask

  task automatic test_train_run();
    run_and_check("train_n3", 3, 1'b1, 0, 1'b0);
  endtask

  task automatic test_inference_run();
    run_and_check("infer_n3", 3, 1'b0, 0, 1'b0);
  endtask

  task automatic test_zero_layers();
    run_and_check("empty_n0", 0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_and_check("backpressure", 3, 1'b1, 2, 1'b0);
  endtask

  task automatic test_oversize();
    apply_reset();
    run_and_check("oversize_n20", 20, 1'b0, 0, 1'b0);
  endtask

  task automatic test_abort();
    bit found = 1'b0;
    apply_reset();
    randomize_table();
    @(negedge clk);
    start = 1'b1; train = 1'b1; num_layers = 5'd3; job_ready = 1'b1; eng_done = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (job_valid && job_layer == 4'd1 && !job_bwd) found = 1'b1;
      eng_done = busy && !job_valid && !lt_rd_en;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("[TB] FAIL abort_reach_1F: got timeout, want job L1 fwd");
    end
    @(negedge clk);
    eng_done = 1'b1; abort = 1'b1;
    @(negedge clk);
    eng_done = 1'b0; abort = 1'b0;
    n_checks++;
    if ({aborted, busy, job_valid, lt_rd_en, run_done} !== 5'b10000) begin
      n_fail++;
      $display("[TB] FAIL abort_response: got ab=%0b busy=%0b v=%0b rd=%0b done=%0b, want 1 0 0 0 0",
               aborted, busy, job_valid, lt_rd_en, run_done);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if ({aborted, run_done, busy} !== 3'b000) begin
        n_fail++;
        $display("[TB] FAIL abort_quiet: got ab=%0b done=%0b busy=%0b, want 0 0 0", aborted, run_done, busy);
      end
    end
    run_and_check("after_abort", 2, 1'b0, 0, 1'b0);
  endtask

  task automatic test_errors();
    bit found = 1'b0;
    apply_reset();
    @(negedge clk);
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0; abort = 1'b1;
    n_checks++;
    if ({err, busy} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL idle_eng_done: got err=%0b busy=%0b, want 1 0", err, busy);
    end
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if ({aborted, busy} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL idle_abort: got ab=%0b busy=%0b, want 0 0", aborted, busy);
    end
    apply_reset();
    run_and_check("start_busy", 3, 1'b1, 0, 1'b1);

    @(negedge clk);
    start = 1'b1; train = 1'b1; num_layers = 5'd4; job_ready = 1'b1;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (job_valid && job_layer == 4'd2) found = 1'b1;
      eng_done = busy && !job_valid && !lt_rd_en;
    end
    n_checks++;
    if (!found || err !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midrun_setup: got found=%0b err=%0b, want 1 1", found, err);
    end
    rst = 1'b1; eng_done = 1'b0;
    @(negedge clk);
    rst = 1'b0; job_ready = 1'b0;
    n_checks++;
    if ({job_valid, lt_rd_en, busy, run_done, aborted, err, job_bwd, lt_idx, job_layer} !== 15'd0) begin
      n_fail++;
      $display("[TB] FAIL midrun_reset: got v=%0b busy=%0b err=%0b L%0d idx=%0d, want all 0",
               job_valid, busy, err, job_layer, lt_idx);
    end
  endtask

  task automatic test_random_runs();
    for (int r = 0; r < 5; r++) begin
      apply_reset();
      run_and_check($sformatf("random%0d", r), int'($urandom_range(1, 16)),
                    1'($urandom_range(0, 1)), 1, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; train = 1'b0; abort = 1'b0;
    num_layers = 5'd0; job_ready = 1'b0; eng_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_train_run();
    test_inference_run();
    test_zero_layers();
    test_backpressure();
    test_abort();
    test_errors();
    test_oversize();
    test_random_runs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_scheduler.md
LAYER_SCHEDULER -- requirements
Module: layer_scheduler

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on posedge clk.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port start, input, 1, one-cycle run request, sampled only in IDLE.
REQ-004 SHALL have port train, input, 1, sampled with start; 1 = forward then backward, 0 = forward only.
REQ-005 SHALL have port abort, input, 1, cancels the run in progress.
REQ-006 SHALL have port num_layers, input, 5, layer count 0..16 from model manager, sampled with start.
REQ-007 SHALL have port lt_rd_en, output, 1, layer-table read strobe.
REQ-008 SHALL have port lt_idx, output, 4, layer-table read index.
REQ-009 SHALL have port lt_opcode, input, layer_opcode, table opcode, valid 1 cycle after lt_rd_en, held until next read.
REQ-010 SHALL have ports lt_scratch, lt_weight, lt_bias, input, mem_handle_t each, table handles with the same timing as lt_opcode.
REQ-011 SHALL have ports job_valid, output, 1, and job_ready, input, 1, for the compute-engine job handshake.
REQ-012 SHALL have port job_layer, output, 4, current layer index.
REQ-013 SHALL have port job_bwd, output, 1, 0 = forward, 1 = backward.
REQ-014 SHALL have ports job_opcode, job_scratch, job_weight, job_bias, outputs, pass-through of the lt_* fields.
REQ-015 SHALL have port eng_done, input, 1, engine completion pulse for the accepted job.
REQ-016 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-017 SHALL have ports run_done and aborted, output, 1 each, one-cycle completion and abort pulses.
REQ-018 SHALL have port err, output, 1, sticky flag set by protocol violations.

Function
REQ-019 SHALL implement states IDLE, FETCH, ISSUE, WAIT, DONE.
REQ-020 IDLE: start=1 SHALL latch train and num_layers, set idx=0 and dir=FWD, and go to FETCH; if num_layers=0, SHALL go to DONE instead.
REQ-021 FETCH: SHALL hold lt_rd_en=1 and lt_idx=idx for exactly one cycle, then go to ISSUE.
REQ-022 ISSUE: SHALL drive job_valid=1; job_* fields SHALL equal the lt_* data and idx/dir, and SHALL stay stable until the handshake; job_valid & job_ready SHALL go to WAIT.
REQ-023 WAIT: eng_done SHALL advance to the next layer; eng_done in any other state SHALL be ignored and SHALL set err.
REQ-024 Forward advance: SHALL go to FETCH with idx+1 if idx < N-1; at idx = N-1 with train=1, SHALL set dir=BWD, keep idx = N-1, and go to FETCH; at idx = N-1 with train=0, SHALL go to DONE.
REQ-025 Backward advance: SHALL go to FETCH with idx-1 if idx > 0; at idx = 0, SHALL go to DONE.
REQ-026 DONE: SHALL pulse run_done for one cycle, then go to IDLE.
REQ-027 Latency: start accepted at cycle T SHALL give lt_rd_en at T+1 and job_valid at T+2; eng_done at cycle D SHALL give the next lt_rd_en at D+1.
REQ-028 abort in any non-IDLE state SHALL go to IDLE at the next edge, pulse aborted, suppress run_done, and drop job_valid; abort has priority over eng_done and job_ready in the same cycle.
REQ-029 abort in IDLE SHALL be ignored; start while busy SHALL be ignored and SHALL not alter latched train or num_layers.
REQ-030 num_layers > 16 SHALL set err and be treated as 16.
REQ-031 Index arithmetic SHALL be 4-bit and SHALL never wrap, because the boundary checks precede any increment or decrement.

Reset
REQ-032 rst=1 at a clock edge SHALL force IDLE, idx=0, dir=FWD, and clear err; it overrides any in-flight run.
REQ-033 Reset values SHALL be: job_valid, lt_rd_en, busy, run_done, aborted and err all 0; lt_idx, job_layer and job_bwd all 0.

Structure
REQ-034 layer_opcode and mem_handle_t SHALL come from the existing shared definitions; the state enum SHALL be added to the model-manager define package.
REQ-035 The block SHALL be a single module with no sub-module; the FSM and index counter are local.

Verification
REQ-036 N=3, train=1, job_ready tied 1, eng_done 2 cycles after each accept -> job_layer/job_bwd sequence 0F,1F,2F,2B,1B,0B; one run_done; err=0.
REQ-037 N=3, train=0 -> jobs 0F,1F,2F, then run_done; no backward job issued.
REQ-038 N=0, start -> run_done exactly 2 cycles after start; job_valid never asserts.
REQ-039 job_ready held low 5 cycles in ISSUE -> job_valid and job_opcode/job_scratch stable for all 5 cycles; exactly one job accepted.
REQ-040 abort coincident with eng_done in WAIT at layer 1F -> aborted pulse, IDLE next cycle, no run_done, next start begins at 0F.
REQ-041 Spurious eng_done in IDLE, and start while busy -> err=1, run unaffected; rst=1 mid-run -> all outputs 0 next cycle and err cleared.
